// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I(+M) decode stage with registered output and optional skid entry
module decode_stage #(
  parameter int unsigned EN_M    = 0,
  parameter int unsigned EN_SKID = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_imm,
  output logic [4:0]       out_alu_code,
  output logic             out_op1_sel,
  output logic             out_op2_sel,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_reg_we,
  output logic [2:0]       out_is_load,
  output logic [1:0]       out_is_store,
  output logic             out_is_muldiv,
  output logic [2:0]       out_md_op,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_cnt
);
  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_OPIMM = 7'h13, OPC_OPREG = 7'h33;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3, ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7, ALU_OR = 5'd8, ALU_AND = 5'd9;
  localparam logic [4:0] ALU_LUI = 5'd10, ALU_JAL = 5'd11, ALU_JALR = 5'd12, ALU_BEQ = 5'd13;
  localparam logic [4:0] ALU_BNE = 5'd14, ALU_BLT = 5'd15, ALU_BGE = 5'd16, ALU_BLTU = 5'd17, ALU_BGEU = 5'd18;
  localparam logic ALU_OP1_RS1 = 1'b0, ALU_OP1_PC = 1'b1, ALU_OP2_RS2 = 1'b0, ALU_OP2_IMM = 1'b1;
  localparam logic [2:0] LOAD_DISABLE = 3'd0, LOAD_LB = 3'd1, LOAD_LH = 3'd2, LOAD_LW = 3'd3;
  localparam logic [2:0] LOAD_LBU = 3'd4, LOAD_LHU = 3'd5;
  localparam logic [1:0] STORE_DISABLE = 2'd0, STORE_SB = 2'd1, STORE_SH = 2'd2, STORE_SW = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        op1;
    logic        op2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic        md;
    logic [2:0]  md_op;
    logic        ill;
  } entry_t;

  entry_t           dec, out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire, out_fire;
  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_insn[6:0];
  assign funct3 = in_insn[14:12];
  assign funct7 = in_insn[31:25];
  assign imm_i  = {{20{in_insn[31]}}, in_insn[31:20]};
  assign imm_s  = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
  assign imm_b  = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
  assign imm_u  = {in_insn[31:12], 12'b0};
  assign imm_j  = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};

  // alt selects arithmetic right shift; SUB is resolved by the caller
  function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.rs1 = in_insn[19:15];
    dec.rs2 = in_insn[24:20];
    dec.rd  = in_insn[11:7];
    dec.alu = ALU_ADD;
    case (opcode)
      OPC_LUI:   begin dec.imm = imm_u; dec.op1 = ALU_OP1_PC; dec.op2 = ALU_OP2_IMM; dec.alu = ALU_LUI; dec.we = 1'b1; end
      OPC_AUIPC: begin dec.imm = imm_u; dec.op1 = ALU_OP1_PC; dec.op2 = ALU_OP2_IMM; dec.we = 1'b1; end
      OPC_JAL:   begin dec.imm = imm_j; dec.op1 = ALU_OP1_PC; dec.op2 = ALU_OP2_IMM; dec.alu = ALU_JAL; dec.we = 1'b1; end
      OPC_JALR:  begin dec.imm = imm_i; dec.op2 = ALU_OP2_IMM; dec.alu = ALU_JALR; dec.we = 1'b1; end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        case (funct3)
          3'b000:  dec.alu = ALU_BEQ;
          3'b001:  dec.alu = ALU_BNE;
          3'b100:  dec.alu = ALU_BLT;
          3'b101:  dec.alu = ALU_BGE;
          3'b110:  dec.alu = ALU_BLTU;
          3'b111:  dec.alu = ALU_BGEU;
          default: dec.ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm = imm_i; dec.op2 = ALU_OP2_IMM; dec.we = 1'b1;
        case (funct3)
          3'b000:  dec.ld = LOAD_LB;
          3'b001:  dec.ld = LOAD_LH;
          3'b010:  dec.ld = LOAD_LW;
          3'b100:  dec.ld = LOAD_LBU;
          3'b101:  dec.ld = LOAD_LHU;
          default: dec.ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.imm = imm_s; dec.op2 = ALU_OP2_IMM;
        case (funct3)
          3'b000:  dec.st = STORE_SB;
          3'b001:  dec.st = STORE_SH;
          3'b010:  dec.st = STORE_SW;
          default: dec.ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin dec.imm = imm_i; dec.op2 = ALU_OP2_IMM; dec.we = 1'b1; dec.alu = alu_of(funct3, in_insn[30]); end
      OPC_OPREG: begin
        dec.we = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (EN_M != 0) begin dec.md = 1'b1; dec.md_op = funct3; end
          else dec.ill = 1'b1;
        end else if (funct7 == 7'b0000000) dec.alu = alu_of(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec.alu = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) dec.alu = ALU_SRA;
        else dec.ill = 1'b1;
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec.ld = LOAD_DISABLE; dec.st = STORE_DISABLE; dec.md = 1'b0; dec.md_op = 3'b0; dec.alu = ALU_ADD;
    end
    if (dec.ill || dec.rd == 5'd0) dec.we = 1'b0;
  end

  assign in_ready = (EN_SKID != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // A pending skid entry always refills the output register before new input is taken
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_fire) cnt_d = cnt_q + CNT_W'(1);
      if (out_fire || !out_valid_q) begin
        if (skid_valid_q) begin
          out_d = skid_q; out_valid_d = 1'b1; skid_valid_d = 1'b0;
        end else begin
          out_valid_d = in_fire;
          if (in_fire) out_d = dec;
        end
      end else if (in_fire && EN_SKID != 0) begin
        skid_d = dec; skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_q.pc;
  assign out_imm       = out_q.imm;
  assign out_alu_code  = out_q.alu;
  assign out_op1_sel   = out_q.op1;
  assign out_op2_sel   = out_q.op2;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_reg_we    = out_q.we;
  assign out_is_load   = out_q.ld;
  assign out_is_store  = out_q.st;
  assign out_is_muldiv = out_q.md;
  assign out_md_op     = out_q.md_op;
  assign out_illegal   = out_q.ill;
  assign dec_cnt       = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage (default, EN_M/CNT_W=4, and no-skid builds)
module tb_decode_stage;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_LUI = 5'd10, ALU_JAL = 5'd11, ALU_BEQ = 5'd13;
  localparam logic [2:0] LOAD_DISABLE = 3'd0, LOAD_LW = 3'd3;
  localparam logic [1:0] STORE_DISABLE = 2'd0, STORE_SW = 2'd3;

  logic clk = 1'b0, rst, flush, in_valid, out_ready;
  logic [31:0] in_insn, in_pc;
  always #5 clk = ~clk;

  logic in_ready, out_valid, out_op1_sel, out_op2_sel, out_reg_we, out_is_muldiv, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0] out_alu_code, out_rs1, out_rs2, out_rd;
  logic [2:0] out_is_load, out_md_op;
  logic [1:0] out_is_store;
  logic [15:0] dec_cnt;

  logic m_in_ready, m_out_valid, m_op1, m_op2, m_reg_we, m_is_muldiv, m_illegal;
  logic [31:0] m_pc, m_imm;
  logic [4:0] m_alu, m_rs1, m_rs2, m_rd;
  logic [2:0] m_is_load, m_md_op;
  logic [1:0] m_is_store;
  logic [3:0] m_dec_cnt;

  logic ns_in_ready, ns_out_valid, ns_op1, ns_op2, ns_reg_we, ns_is_muldiv, ns_illegal;
  logic [31:0] ns_pc, ns_imm;
  logic [4:0] ns_alu, ns_rs1, ns_rs2, ns_rd;
  logic [2:0] ns_is_load, ns_md_op;
  logic [1:0] ns_is_store;
  logic [15:0] ns_dec_cnt;

  decode_stage dut (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_imm(out_imm), .out_alu_code(out_alu_code), .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_reg_we(out_reg_we), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_is_muldiv(out_is_muldiv), .out_md_op(out_md_op),
    .out_illegal(out_illegal), .dec_cnt(dec_cnt));

  decode_stage #(.EN_M(1), .EN_SKID(1), .CNT_W(4)) dut_m (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(m_in_ready), .in_insn(in_insn), .in_pc(in_pc), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_pc(m_pc), .out_imm(m_imm), .out_alu_code(m_alu), .out_op1_sel(m_op1),
    .out_op2_sel(m_op2), .out_rs1(m_rs1), .out_rs2(m_rs2), .out_rd(m_rd), .out_reg_we(m_reg_we),
    .out_is_load(m_is_load), .out_is_store(m_is_store), .out_is_muldiv(m_is_muldiv), .out_md_op(m_md_op),
    .out_illegal(m_illegal), .dec_cnt(m_dec_cnt));

  decode_stage #(.EN_M(0), .EN_SKID(0), .CNT_W(16)) dut_ns (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ns_in_ready), .in_insn(in_insn), .in_pc(in_pc), .out_valid(ns_out_valid),
    .out_ready(out_ready), .out_pc(ns_pc), .out_imm(ns_imm), .out_alu_code(ns_alu), .out_op1_sel(ns_op1),
    .out_op2_sel(ns_op2), .out_rs1(ns_rs1), .out_rs2(ns_rs2), .out_rd(ns_rd), .out_reg_we(ns_reg_we),
    .out_is_load(ns_is_load), .out_is_store(ns_is_store), .out_is_muldiv(ns_is_muldiv), .out_md_op(ns_md_op),
    .out_illegal(ns_illegal), .dec_cnt(ns_dec_cnt));

  typedef struct {
    logic [31:0] pc, imm;
    logic [4:0]  alu;
    logic        op1, op2;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0, errors = 0, exp_cnt = 0;

  function automatic exp_t mk(input logic [31:0] pc, imm, input logic [4:0] alu, input logic op1, op2,
                              input logic [4:0] rd, input logic we, input logic [2:0] ld,
                              input logic [1:0] st, input logic ill);
    exp_t e;
    e.pc = pc; e.imm = imm; e.alu = alu; e.op1 = op1; e.op2 = op2;
    e.rd = rd; e.we = we; e.ld = ld; e.st = st; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  task automatic step; @(posedge clk); #1; endtask
  task automatic idle; in_valid = 1'b0; flush = 1'b0; endtask
  task automatic send(input logic [31:0] insn, input logic [31:0] pc, input exp_t e);
    in_valid = 1'b1; in_insn = insn; in_pc = pc; sb_q.push_back(e);
  endtask

  // Immediate and operand selects are only meaningful for legal entries
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      exp_t e;
      exp_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++; $display("FAIL sb_unexpected: got entry pc=%h, required no entry", out_pc);
      end else begin
        e = sb_q.pop_front();
        if (out_pc !== e.pc || out_alu_code !== e.alu || out_rd !== e.rd || out_reg_we !== e.we ||
            out_is_load !== e.ld || out_is_store !== e.st || out_illegal !== e.ill ||
            (!e.ill && (out_imm !== e.imm || out_op1_sel !== e.op1 || out_op2_sel !== e.op2))) begin
          errors++;
          $display("FAIL sb_entry: got pc=%h imm=%h alu=%0d op=%b%b rd=%0d we=%b ld=%0d st=%0d ill=%b, required pc=%h imm=%h alu=%0d op=%b%b rd=%0d we=%b ld=%0d st=%0d ill=%b",
                   out_pc, out_imm, out_alu_code, out_op1_sel, out_op2_sel, out_rd, out_reg_we, out_is_load,
                   out_is_store, out_illegal, e.pc, e.imm, e.alu, e.op1, e.op2, e.rd, e.we, e.ld, e.st, e.ill);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_insn = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    checks++; if (dec_cnt !== 16'd0) begin errors++; $display("FAIL rst_dec_cnt: got %0d required 0", dec_cnt); end
    checks++; if (out_pc !== 32'd0 || out_imm !== 32'd0) begin errors++; $display("FAIL rst_data: got pc=%h imm=%h required 0", out_pc, out_imm); end
    step; rst = 1'b0; exp_cnt = 0; sb_q.delete();
  endtask

  task automatic test_addi;
    out_ready = 1'b1;
    send(32'hFFF00093, 32'h100, mk(32'h100, 32'hFFFFFFFF, ALU_ADD, 1'b0, 1'b1, 5'd1, 1'b1, LOAD_DISABLE, STORE_DISABLE, 1'b0));
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_pre_valid: got %b required 0", out_valid); end
    step; idle;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_latency: got out_valid=%b required 1", out_valid); end
    checks++;
    if (out_imm !== 32'hFFFFFFFF || out_alu_code !== ALU_ADD || out_op2_sel !== 1'b1 || out_rd !== 5'd1 || out_reg_we !== 1'b1) begin
      errors++; $display("FAIL addi_fields: got imm=%h alu=%0d op2=%b rd=%0d we=%b required ffffffff 0 1 1 1",
                         out_imm, out_alu_code, out_op2_sel, out_rd, out_reg_we);
    end
    step;
  endtask

  task automatic test_skid;
    out_ready = 1'b0;
    send(addi(5'd2, 12'd1), 32'h200, mk(32'h200, 32'd1, ALU_ADD, 1'b0, 1'b1, 5'd2, 1'b1, LOAD_DISABLE, STORE_DISABLE, 1'b0));
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_rdy0: got %b required 1", in_ready); end
    step;
    send(addi(5'd3, 12'd2), 32'h204, mk(32'h204, 32'd2, ALU_ADD, 1'b0, 1'b1, 5'd3, 1'b1, LOAD_DISABLE, STORE_DISABLE, 1'b0));
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_rdy1: got %b required 1", in_ready); end
    checks++; if (ns_in_ready !== 1'b0) begin errors++; $display("FAIL noskid_rdy_stall: got %b required 0", ns_in_ready); end
    step;
    in_valid = 1'b1; in_insn = addi(5'd4, 12'd3); in_pc = 32'h208;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_rdy_full: got %b required 0", in_ready); end
    checks++; if (out_pc !== 32'h200) begin errors++; $display("FAIL skid_hold: got pc=%h required 200", out_pc); end
    step;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h200) begin errors++; $display("FAIL skid_release: got rdy=%b pc=%h required 0 200", in_ready, out_pc); end
    checks++; if (ns_in_ready !== 1'b1 || ns_pc !== 32'h200) begin errors++; $display("FAIL noskid_passthru: got rdy=%b pc=%h required 1 200", ns_in_ready, ns_pc); end
    step;
    sb_q.push_back(mk(32'h208, 32'd3, ALU_ADD, 1'b0, 1'b1, 5'd4, 1'b1, LOAD_DISABLE, STORE_DISABLE, 1'b0));
    @(negedge clk);
    checks++; if (out_pc !== 32'h204) begin errors++; $display("FAIL skid_order2: got pc=%h required 204", out_pc); end
    step; idle;
    @(negedge clk);
    checks++; if (out_pc !== 32'h208) begin errors++; $display("FAIL skid_order3: got pc=%h required 208", out_pc); end
    step;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || sb_q.size() != 0) begin errors++; $display("FAIL skid_drain: got valid=%b pending=%0d required 0 0", out_valid, sb_q.size()); end
  endtask

  task automatic test_mul;
    out_ready = 1'b1;
    send(32'h02208033, 32'h300, mk(32'h300, 32'd0, ALU_ADD, 1'b0, 1'b0, 5'd0, 1'b0, LOAD_DISABLE, STORE_DISABLE, 1'b1));
    step;
    send(32'h022082B3, 32'h304, mk(32'h304, 32'd0, ALU_ADD, 1'b0, 1'b0, 5'd5, 1'b0, LOAD_DISABLE, STORE_DISABLE, 1'b1));
    @(negedge clk);
    checks++; if (out_illegal !== 1'b1 || out_reg_we !== 1'b0 || out_is_muldiv !== 1'b0) begin errors++; $display("FAIL mul_nom: got ill=%b we=%b md=%b required 1 0 0", out_illegal, out_reg_we, out_is_muldiv); end
    checks++;
    if (m_out_valid !== 1'b1 || m_is_muldiv !== 1'b1 || m_md_op !== 3'b000 || m_illegal !== 1'b0 || m_alu !== ALU_ADD) begin
      errors++; $display("FAIL mul_m: got v=%b md=%b op=%0d ill=%b alu=%0d required 1 1 0 0 0", m_out_valid, m_is_muldiv, m_md_op, m_illegal, m_alu);
    end
    step; idle;
    @(negedge clk);
    checks++; if (m_reg_we !== 1'b1 || m_is_muldiv !== 1'b1 || m_rd !== 5'd5) begin errors++; $display("FAIL mul_m_we: got we=%b md=%b rd=%0d required 1 1 5", m_reg_we, m_is_muldiv, m_rd); end
    step;
  endtask

  task automatic test_decode_table;
    logic [31:0] insn [10];
    exp_t        e    [10];
    insn[0] = 32'h00500013;                                         e[0] = mk(0, 32'd5, ALU_ADD, 0, 1, 5'd0, 0, LOAD_DISABLE, STORE_DISABLE, 0);
    insn[1] = {12'h010, 5'd1, 3'b011, 5'd6, 7'h03};                 e[1] = mk(0, 32'h10, ALU_ADD, 0, 1, 5'd6, 0, LOAD_DISABLE, STORE_DISABLE, 1);
    insn[2] = {12'h010, 5'd1, 3'b010, 5'd6, 7'h03};                 e[2] = mk(0, 32'h10, ALU_ADD, 0, 1, 5'd6, 1, LOAD_LW, STORE_DISABLE, 0);
    insn[3] = {20'h12345, 5'd7, 7'h37};                             e[3] = mk(0, 32'h12345000, ALU_LUI, 1, 1, 5'd7, 1, LOAD_DISABLE, STORE_DISABLE, 0);
    insn[4] = {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'h23};            e[4] = mk(0, 32'hFFFFFFFC, ALU_ADD, 0, 1, 5'h1C, 0, LOAD_DISABLE, STORE_SW, 0);
    insn[5] = {7'h20, 5'd2, 5'd1, 3'b000, 5'd8, 7'h33};             e[5] = mk(0, 32'd0, ALU_SUB, 0, 0, 5'd8, 1, LOAD_DISABLE, STORE_DISABLE, 0);
    insn[6] = {7'h20, 5'd2, 5'd1, 3'b001, 5'd9, 7'h33};             e[6] = mk(0, 32'd0, ALU_ADD, 0, 0, 5'd9, 0, LOAD_DISABLE, STORE_DISABLE, 1);
    insn[7] = {7'h00, 5'd2, 5'd1, 3'b000, 5'b01000, 7'h63};         e[7] = mk(0, 32'd8, ALU_BEQ, 0, 0, 5'd8, 0, LOAD_DISABLE, STORE_DISABLE, 0);
    insn[8] = {1'b0, 10'd8, 1'b0, 8'd0, 5'd1, 7'h6F};               e[8] = mk(0, 32'd16, ALU_JAL, 1, 1, 5'd1, 1, LOAD_DISABLE, STORE_DISABLE, 0);
    insn[9] = {7'h00, 5'd2, 5'd1, 3'b010, 5'd3, 7'h63};             e[9] = mk(0, 32'd0, ALU_ADD, 0, 0, 5'd3, 0, LOAD_DISABLE, STORE_DISABLE, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e[i].pc = 32'h400 + 32'(4 * i);
      send(insn[i], e[i].pc, e[i]);
      step;
    end
    idle;
    repeat (2) step;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL table_drain: got %0d pending required 0", sb_q.size()); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    send(addi(5'd1, 12'd7), 32'h500, mk(32'h500, 32'd7, ALU_ADD, 0, 1, 5'd1, 1, LOAD_DISABLE, STORE_DISABLE, 0));
    step;
    send(addi(5'd2, 12'd8), 32'h504, mk(32'h504, 32'd8, ALU_ADD, 0, 1, 5'd2, 1, LOAD_DISABLE, STORE_DISABLE, 0));
    step;
    in_valid = 1'b1; in_insn = addi(5'd3, 12'd9); in_pc = 32'h508; out_ready = 1'b1; flush = 1'b1;
    sb_q.delete();
    step;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: got valid=%b rdy=%b required 0 1", out_valid, in_ready); end
    checks++; if (dec_cnt !== 16'(exp_cnt) || m_dec_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL flush_cnt: got %0d/%0d required %0d", dec_cnt, m_dec_cnt, exp_cnt); end
    step; idle;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_in: got valid=%b required 0", out_valid); end
    step;
  endtask

  task automatic test_count_wrap;
    rst = 1'b1; step; rst = 1'b0; exp_cnt = 0; sb_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(addi(5'd1, 12'(i)), 32'h600 + 32'(4 * i), mk(32'h600 + 32'(4 * i), 32'(i), ALU_ADD, 0, 1, 5'd1, 1, LOAD_DISABLE, STORE_DISABLE, 0));
      step;
    end
    idle;
    repeat (2) step;
    @(negedge clk);
    checks++; if (m_dec_cnt !== 4'd1) begin errors++; $display("FAIL cnt_wrap4: got %0d required 1", m_dec_cnt); end
    checks++; if (dec_cnt !== 16'd17) begin errors++; $display("FAIL cnt_17: got %0d required 17", dec_cnt); end
    step;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    send(addi(5'd5, 12'h123), 32'h700, mk(32'h700, 32'h123, ALU_ADD, 0, 1, 5'd5, 1, LOAD_DISABLE, STORE_DISABLE, 0));
    step;
    send(addi(5'd6, 12'h456), 32'h704, mk(32'h704, 32'h456, ALU_ADD, 0, 1, 5'd6, 1, LOAD_DISABLE, STORE_DISABLE, 0));
    step; idle;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_ctrl: got valid=%b rdy=%b required 0 1", out_valid, in_ready); end
    checks++; if (out_pc !== 32'd0 || out_imm !== 32'd0 || out_rd !== 5'd0 || out_reg_we !== 1'b0) begin errors++; $display("FAIL arst_data: got pc=%h imm=%h rd=%0d we=%b required 0", out_pc, out_imm, out_rd, out_reg_we); end
    checks++; if (dec_cnt !== 16'd0 || m_dec_cnt !== 4'd0) begin errors++; $display("FAIL arst_cnt: got %0d/%0d required 0", dec_cnt, m_dec_cnt); end
    sb_q.delete(); exp_cnt = 0;
    step; rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_discard: got valid=%b required 0", out_valid); end
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_addi;
    test_skid;
    test_mul;
    test_decode_table;
    test_flush;
    test_count_wrap;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
